// File: rtl/sdram_ctrl_pkg.sv
// sdram_ctrl_pkg: SDRAM command encodings and sequencer state type.
package sdram_ctrl_pkg;

    localparam logic [2:0] CMD_NOP       = 3'b000;
    localparam logic [2:0] CMD_ACTIVE    = 3'b001;
    localparam logic [2:0] CMD_READ      = 3'b010;
    localparam logic [2:0] CMD_WRITE     = 3'b011;
    localparam logic [2:0] CMD_PRECHARGE = 3'b100;
    localparam logic [2:0] CMD_REFRESH   = 3'b101;

    typedef enum logic [3:0] {
        IDLE,
        ACTIVATE,
        WAIT_RCD,
        RD,
        WR,
        WAIT_CAS,
        PRECHARGE,
        WAIT_RP,
        REFRESH,
        WAIT_RFC
    } state_t;

endpackage

// File: rtl/sdram_ctrl_timer.sv
// sdram_ctrl_timer: loadable down-counter that parks at zero and flags it.
module sdram_ctrl_timer #(
    parameter int unsigned     WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down until zero is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-bank SDRAM command sequencer (ACTIVE -> READ/WRITE ->
// PRECHARGE) with tRCD / CAS / tRP timing and a read data_valid pulse.
// Optional periodic auto-refresh is enabled by defining AUTO_REFRESH_EN.
module sdram_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int unsigned T_RCD            = 2,
    parameter int unsigned T_CAS            = 3,
`ifdef AUTO_REFRESH_EN
    parameter int unsigned REFRESH_INTERVAL = 64,
    parameter int unsigned T_RFC            = 4,
`endif
    parameter int unsigned T_RP             = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read_req,
    input  logic       write_req,
    output logic [2:0] sdram_cmd,
    output logic       data_valid
);

    localparam int unsigned T_MAX3 = (T_RCD > T_CAS) ? ((T_RCD > T_RP) ? T_RCD : T_RP)
                                                     : ((T_CAS > T_RP) ? T_CAS : T_RP);
`ifdef AUTO_REFRESH_EN
    localparam int unsigned T_MAX  = (T_MAX3 > T_RFC) ? T_MAX3 : T_RFC;
`else
    localparam int unsigned T_MAX  = T_MAX3;
`endif
    localparam int unsigned CW     = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);

    // Load values count the NOP cycles remaining after the cycle that loads them.
    localparam logic [CW-1:0] LD_RCD = CW'((T_RCD > 1) ? T_RCD - 2 : 0);
    localparam logic [CW-1:0] LD_CAS = CW'((T_CAS > 1) ? T_CAS - 2 : 0);
    localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
`ifdef AUTO_REFRESH_EN
    localparam logic [CW-1:0] LD_RFC = CW'(T_RFC - 1);
    localparam int unsigned   RW     = $clog2(REFRESH_INTERVAL + 1);
`endif

    state_t          state;
    logic            is_write;
    logic            tmr_load;
    logic [CW-1:0]   tmr_value;
    logic            tmr_zero;

    // Reload the sequence timer whenever the FSM is about to enter a wait state.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ACTIVATE:  begin tmr_load = 1'b1; tmr_value = LD_RCD; end
            RD:        begin tmr_load = 1'b1; tmr_value = LD_CAS; end
            PRECHARGE: begin tmr_load = 1'b1; tmr_value = LD_RP;  end
`ifdef AUTO_REFRESH_EN
            REFRESH:   begin tmr_load = 1'b1; tmr_value = LD_RFC; end
`endif
            default:   ;
        endcase
    end

    sdram_ctrl_timer #(
        .WIDTH       (CW),
        .RESET_VALUE ('0)
    ) u_seq_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .zero       (tmr_zero)
    );

`ifdef AUTO_REFRESH_EN
    logic refresh_pending;
    logic ref_zero;
    logic ref_load;

    // REFRESH is issued on the edge where IDLE sees a pending refresh.
    assign ref_load = (state == IDLE) && refresh_pending;

    sdram_ctrl_timer #(
        .WIDTH       (RW),
        .RESET_VALUE (RW'(REFRESH_INTERVAL))
    ) u_ref_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (ref_load),
        .load_value (RW'(REFRESH_INTERVAL)),
        .zero       (ref_zero)
    );

    // Latch interval expiry until the refresh is actually issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_pending <= 1'b0;
        end else if (ref_load) begin
            refresh_pending <= 1'b0;
        end else if (ref_zero) begin
            refresh_pending <= 1'b1;
        end
    end
`endif

    // Command sequencer; sdram_cmd/data_valid are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sdram_cmd  <= CMD_NOP;
            data_valid <= 1'b0;
            is_write   <= 1'b0;
        end else begin
            sdram_cmd  <= CMD_NOP;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
`ifdef AUTO_REFRESH_EN
                    if (refresh_pending) begin
                        state     <= REFRESH;
                        sdram_cmd <= CMD_REFRESH;
                    end else
`endif
                    if (write_req || read_req) begin
                        state     <= ACTIVATE;
                        sdram_cmd <= CMD_ACTIVE;
                        is_write  <= write_req;
                    end
                end
                ACTIVATE, WAIT_RCD: begin
                    if (state == WAIT_RCD ? tmr_zero : (T_RCD == 1)) begin
                        state     <= is_write ? WR : RD;
                        sdram_cmd <= is_write ? CMD_WRITE : CMD_READ;
                    end else begin
                        state <= WAIT_RCD;
                    end
                end
                RD, WAIT_CAS: begin
                    if (state == WAIT_CAS ? tmr_zero : (T_CAS == 1)) begin
                        state      <= PRECHARGE;
                        sdram_cmd  <= CMD_PRECHARGE;
                        data_valid <= 1'b1;
                    end else begin
                        state <= WAIT_CAS;
                    end
                end
                WR: begin
                    state     <= PRECHARGE;
                    sdram_cmd <= CMD_PRECHARGE;
                end
                PRECHARGE: state <= WAIT_RP;
                WAIT_RP:   if (tmr_zero) state <= IDLE;
`ifdef AUTO_REFRESH_EN
                REFRESH:   state <= WAIT_RFC;
                WAIT_RFC:  if (tmr_zero) state <= IDLE;
`endif
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: directed checks of the sdram_ctrl command sequences.
// With AUTO_REFRESH_EN defined the refresh scenarios run instead of the
// read/write scenarios (REFRESH_INTERVAL overridden to 16).
module tb_sdram_ctrl;

    logic       clk;
    logic       reset;
    logic       read_req;
    logic       write_req;
    logic [2:0] sdram_cmd;
    logic       data_valid;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [2:0] exp_wr [7] = '{3'b001, 3'b000, 3'b011, 3'b100, 3'b000, 3'b000, 3'b000};
    logic [2:0] exp_rd [9] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
    logic       exp_dv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    sdram_ctrl #(
        .T_RCD            (2),
        .T_CAS            (3),
`ifdef AUTO_REFRESH_EN
        .REFRESH_INTERVAL (16),
        .T_RFC            (4),
`endif
        .T_RP             (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_req   (read_req),
        .write_req  (write_req),
        .sdram_cmd  (sdram_cmd),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] ec, input logic ed);
        checks++;
        assert (sdram_cmd === ec) else begin
            errors++;
            $error("FAIL %s sdram_cmd: observed %b expected %b", tag, sdram_cmd, ec);
        end
        checks++;
        assert (data_valid === ed) else begin
            errors++;
            $error("FAIL %s data_valid: observed %b expected %b", tag, data_valid, ed);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] ec, input logic ed);
        @(negedge clk);
        check(tag, ec, ed);
    endtask

    initial begin
        reset     = 1'b0;
        read_req  = 1'b1;
        write_req = 1'b1;

        // Reset held with both requests high
        #1 check("rst async", 3'b000, 1'b0);
        step("rst c0", 3'b000, 1'b0);
        step("rst c1", 3'b000, 1'b0);
        read_req  = 1'b0;
        write_req = 1'b0;
        reset     = 1'b1;

`ifdef AUTO_REFRESH_EN
        // Interval expiry while idle: REFRESH, 4 NOPs, then idle
        for (int i = 1; i <= 17; i++) step($sformatf("ref idle n%0d", i), 3'b000, 1'b0);
        step("ref issue", 3'b101, 1'b0);
        for (int i = 0; i < 4; i++) step($sformatf("ref rfc%0d", i), 3'b000, 1'b0);
        step("ref back idle", 3'b000, 1'b0);

        // Request coincident with a pending refresh is dropped
        for (int i = 24; i <= 35; i++) step($sformatf("ref2 idle n%0d", i), 3'b000, 1'b0);
        write_req = 1'b1;
        step("ref2 issue", 3'b101, 1'b0);
        write_req = 1'b0;
        for (int i = 0; i < 6; i++) step($sformatf("ref2 after%0d", i), 3'b000, 1'b0);
`else
        step("idle0", 3'b000, 1'b0);
        step("idle1", 3'b000, 1'b0);

        // Single write
        write_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step($sformatf("wr c%0d", i), exp_wr[i], 1'b0);
            write_req = 1'b0;
        end

        // Single read
        read_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step($sformatf("rd c%0d", i), exp_rd[i], exp_dv[i]);
            read_req = 1'b0;
        end

        // Both requests: write wins; a read pulse at c2 is ignored
        read_req  = 1'b1;
        write_req = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step($sformatf("col c%0d", i), exp_wr[i], 1'b0);
            read_req  = (i == 1);
            write_req = 1'b0;
        end
        step("col idle", 3'b000, 1'b0);

        // Held write: back-to-back with one IDLE cycle between
        write_req = 1'b1;
        for (int i = 0; i < 7; i++) step($sformatf("b2b a c%0d", i), exp_wr[i], 1'b0);
        for (int i = 0; i < 7; i++) begin
            step($sformatf("b2b b c%0d", i), exp_wr[i], 1'b0);
            write_req = 1'b0;
        end

        // Reset in c3 of a read: no PRECHARGE or data_valid afterwards
        read_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("rdrst c%0d", i), exp_rd[i], 1'b0);
            read_req = 1'b0;
        end
        reset = 1'b0;
        #1 check("rdrst async", 3'b000, 1'b0);
        step("rdrst hold", 3'b000, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) step($sformatf("rdrst after%0d", i), 3'b000, 1'b0);

        // Asynchronous reset while ACTIVE is on the bus
        write_req = 1'b1;
        step("wrrst c0", 3'b001, 1'b0);
        write_req = 1'b0;
        reset = 1'b0;
        #1 check("wrrst async", 3'b000, 1'b0);
        step("wrrst hold", 3'b000, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("wrrst after%0d", i), 3'b000, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_ctrl.md
Name: sdram_ctrl

Overview:
- Single-bank SDRAM command sequencer that turns one-cycle read/write requests into an ACTIVE → READ/WRITE → PRECHARGE sequence.
- Enforces tRCD, CAS latency and tRP timing.
- Flags read-data return with a one-cycle data_valid pulse.
- Sits between a simple request master and the SDRAM command pins. No address or data path in this block.

Parameters:
- T_RCD, 2, cycles from ACTIVE to READ/WRITE (>=1)
- T_CAS, 3, cycles from READ to data_valid (>=1)
- T_RP, 2, NOP cycles after PRECHARGE before returning to IDLE (>=1)
- REFRESH_INTERVAL, 64, cycles between auto-refreshes (only with AUTO_REFRESH_EN)
- T_RFC, 4, NOP cycles after REFRESH (only with AUTO_REFRESH_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- read_req  in  1  read request, sampled only in IDLE
- write_req  in  1  write request, sampled only in IDLE
- sdram_cmd  out  3  SDRAM command: NOP=000, ACTIVE=001, READ=010, WRITE=011, PRECHARGE=100, REFRESH=101
- data_valid  out  1  one-cycle pulse when read data is valid

Behaviour:
- Outputs are registered.
- While reset=0 (asynchronous), and after release: state=IDLE, sdram_cmd=NOP, data_valid=0.
- States: IDLE, ACTIVATE, WAIT_RCD, RD, WR, WAIT_CAS, PRECHARGE, WAIT_RP (plus REFRESH, WAIT_RFC with the option).
- Cycle numbering: c0 is the cycle immediately after the rising edge on which IDLE sampled a request.
- Write sequence:
  - c0 ACTIVE.
  - c1..c(T_RCD-1) NOP.
  - c(T_RCD) WRITE.
  - c(T_RCD+1) PRECHARGE.
  - Next T_RP cycles NOP (WAIT_RP).
  - Then IDLE.
- Read sequence:
  - c0 ACTIVE.
  - NOPs to c(T_RCD).
  - c(T_RCD) READ.
  - NOPs through c(T_RCD+T_CAS-1).
  - c(T_RCD+T_CAS): PRECHARGE with data_valid=1 for exactly this cycle.
  - Next T_RP cycles NOP.
  - Then IDLE.
- With defaults:
  - Write: ACTIVE@c0, WRITE@c2, PRECHARGE@c3, NOP c4-c5, IDLE at c6.
  - Read: ACTIVE@c0, READ@c2, NOP c3-c4, PRECHARGE+data_valid@c5, NOP c6-c7, IDLE at c8.
- IDLE outputs NOP.
- A new request can be accepted on the edge ending the first IDLE cycle.
- read_req and write_req both high in IDLE: write wins; the read is dropped.
- Requests while not in IDLE are ignored. No queuing, no busy output.
- A held request issues back-to-back transactions, each separated by at least one IDLE cycle.
- data_valid is never asserted outside a read sequence and never for more than one cycle per read.
- Reset mid-sequence aborts immediately: sdram_cmd=NOP, data_valid=0, IDLE. No PRECHARGE is issued.
- Timing counters are wide enough for max(T_RCD, T_CAS, T_RP, T_RFC) and REFRESH_INTERVAL. A counter loads on state entry and the state exits when the counter reaches zero.

Optional Feature:
- Macro: AUTO_REFRESH_EN.
- Defined:
  - A free-running counter starts at REFRESH_INTERVAL after reset and counts down every cycle, including when busy.
  - On expiry it sets refresh_pending.
  - In IDLE, refresh_pending has priority over requests.
  - Refresh sequence: REFRESH for 1 cycle, then T_RFC NOP cycles, then IDLE.
  - refresh_pending clears and the counter reloads when REFRESH is issued.
  - Requests arriving during refresh are ignored.
- Undefined: REFRESH (101) is never driven, and no counter logic exists.

Decomposition:
- Package sdram_ctrl_pkg holds:
  - the 3-bit command encoding localparams;
  - the state enum typedef.
- One sub-module, sdram_ctrl_timer: a loadable down-counter with a zero flag, instantiated for sequence timing. It is instantiated a second time for the refresh interval under AUTO_REFRESH_EN.

Test Plan:
- Reset: hold reset=0 for 2 cycles with both requests high -> sdram_cmd=000, data_valid=0 throughout. After release the block is in IDLE.
- Write: write_req=1 for one edge -> commands 001,000,011,100,000,000, then idle NOP. data_valid stays 0.
- Read: read_req=1 for one edge -> commands 001,000,010,000,000,100(+data_valid=1),000,000. data_valid is high in exactly one cycle, 5 cycles after the sampling edge.
- Collision and ignore: read_req and write_req both high -> write sequence only. A read_req pulse at c2 of that write -> no read issued.
- Reset mid-read: drive reset=0 at c3 of a read -> sdram_cmd=000 and data_valid=0 asynchronously. No PRECHARGE and no data_valid follow.
- AUTO_REFRESH_EN, REFRESH_INTERVAL=16:
  - Idle -> 101 at the expiry point, then 4 NOPs.
  - A request coincident with refresh_pending -> refresh first; the request is dropped.
